blink_pattern_rx: RTL and testbench

Receive-side counterpart of the board's LED pattern blinker: samples a single-bit optical/pin input that carries a slot-timed on/off pattern and reconstructs the pattern word. The input is synchronized, debounced and edge-aligned. Slots are then sampled at their midpoints and the recovered word is presented with a one-cycle valid strobe. It sits between an input pin (photodiode or jumper from another board's LED) and user logic, all on the 16 MHz CLK domain.

---
 rtl/blink_pattern_rx_if.sv | 21 ++
 rtl/blink_pattern_rx.sv | 163 ++++++++++++++++
 tb/tb_blink_pattern_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/blink_pattern_rx_if.sv
// Pin-side and user-side signals of the blink pattern receiver.
// The receiver takes the slave view. Whatever drives the pin and consumes the pattern takes the master view.
interface blink_pattern_rx_if #(
  parameter int BITS = 32
);
  logic            pin_in;
  logic [BITS-1:0] pattern;
  logic            valid;
  logic            busy;
  logic            err;

  modport master (
    output pin_in,
    input  pattern, valid, busy, err
  );

  modport slave (
    input  pin_in,
    output pattern, valid, busy, err
  );
endinterface

// File: rtl/blink_pattern_rx.sv
// Recovers a slot-timed on/off pattern word from an asynchronous pin.
// Input path: synchronize, debounce, align on the first rising edge. Each slot is then sampled at its midpoint.
module blink_pattern_rx #(
  parameter int SLOT_LOG2 = 21,
  parameter int BITS      = 32,
  parameter int DEBOUNCE  = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  blink_pattern_rx_if.slave bus
);

  localparam int SW = SLOT_LOG2;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
  // Slot midpoint, 2^(SLOT_LOG2-1), as a phase within one slot.
  localparam logic [SW-1:0] HALF = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_deb;
  logic            r_deb_d;
  logic [DW-1:0]   r_deb_cnt;
  logic [SW-1:0]   r_cnt;
  logic [BW-1:0]   r_idx;
  logic [BITS-1:0] r_shift;
  logic [BITS-1:0] r_pattern;
  logic            r_err;

  logic            w_rise;
  logic            w_mid;
  logic            w_start_frame;
  logic            w_store;
  logic            w_last;
  logic            w_abort;
  logic [BITS-1:0] w_shift_next;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.pin_in;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // Any cycle that agrees with the debounced level restarts the stability count.
      if (r_sync2 != r_deb) begin
        if (r_deb_cnt == DW'(DEBOUNCE - 1)) begin
          r_deb     <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DW'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_d;
  assign w_mid  = (r_cnt == HALF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next        = r_state;
    w_start_frame = 1'b0;
    w_store       = 1'b0;
    w_last        = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_start_frame = 1'b1;
          w_next        = S_START;
        end
      end
      S_START: begin
        // A start slot that reads low at its midpoint was only a glitch.
        if (w_mid) begin
          if (r_deb) begin
            w_store = 1'b1;
            w_next  = S_DATA;
          end else begin
            w_abort = 1'b1;
            w_next  = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_mid) begin
          w_store = 1'b1;
          if (r_idx == BW'(BITS - 1)) begin
            w_last = 1'b1;
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift_next        = r_shift;
    w_shift_next[r_idx] = r_deb;
  end

  // The slot phase counter wraps every slot, so matching HALF finds every slot midpoint.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_pattern <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (w_start_frame) begin
        r_cnt   <= '0;
        r_idx   <= '0;
        r_shift <= '0;
      end else begin
        r_cnt <= r_cnt + SW'(1);
        if (w_store) begin
          r_shift <= w_shift_next;
          r_idx   <= r_idx + BW'(1);
        end
      end
      // Loaded on entry to DONE, so the new word is visible in the same cycle as VALID.
      if (w_last) begin
        r_pattern <= w_shift_next;
      end
    end
  end

  assign bus.pattern = r_pattern;
  assign bus.valid   = (r_state == S_DONE);
  assign bus.busy    = (r_state == S_START) || (r_state == S_DATA);
  assign bus.err     = r_err;

endmodule

// File: tb/tb_blink_pattern_rx.sv
// Directed bench for blink_pattern_rx with 16-cycle slots, 8-bit frames and a debounce of 2.
// A negedge monitor logs VALID/ERR events. The main sequence compares them with hand-computed values.
module tb_blink_pattern_rx;

  localparam int SL = 4;
  localparam int NB = 8;
  localparam int DB = 2;
  localparam int SLOT = 1 << SL;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blink_pattern_rx_if #(.BITS(NB)) bus ();

  blink_pattern_rx #(
    .SLOT_LOG2(SL),
    .BITS     (NB),
    .DEBOUNCE (DB)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int       valid_cnt = 0;
  int       err_cnt   = 0;
  int       both_cnt  = 0;
  int       t_start   = 0;
  int       lat_valid = -1;
  int       lat_err   = -1;
  logic     prev_busy = 1'b0;
  logic     busy_prev_at_valid = 1'b0;
  logic     busy_at_valid = 1'b1;
  logic [NB-1:0] log_pat [64];
  int            log_t   [64];

  always @(negedge clk) begin
    if (bus.busy && !prev_busy) t_start = cyc;
    if (bus.valid) begin
      if (valid_cnt < 64) begin
        log_pat[valid_cnt] = bus.pattern;
        log_t[valid_cnt]   = cyc;
      end
      lat_valid          = cyc - t_start;
      busy_prev_at_valid = prev_busy;
      busy_at_valid      = bus.busy;
      valid_cnt++;
    end
    if (bus.err) begin
      lat_err = cyc - t_start;
      err_cnt++;
    end
    if (bus.valid && bus.err) both_cnt++;
    prev_busy = bus.busy;
  end

  task automatic send_frame(input logic [NB-1:0] bits, input bit bounce);
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < SLOT; c++) begin
        if (bounce && c == 5 && (k == 0 || k == 2)) bus.pin_in = ~bits[k];
        else                                        bus.pin_in = bits[k];
        @(negedge clk);
      end
    end
    bus.pin_in = 1'b0;
  endtask

  int v0;
  int e0;

  initial begin
    rst_n      = 1'b0;
    bus.pin_in = 1'b0;

    // Reset held while the pin toggles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.pin_in = i[0];
    end
    check("rst_pattern", 32'(bus.pattern), 32'h0);
    check("rst_valid",   32'(bus.valid),   32'h0);
    check("rst_busy",    32'(bus.busy),    32'h0);
    check("rst_err",     32'(bus.err),     32'h0);
    @(negedge clk);
    bus.pin_in = 1'b0;
    rst_n      = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy",  32'(bus.busy), 32'h0);
    check("idle_valid", 32'(valid_cnt), 32'h0);

    // Single clean frame.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'b0101_0011, 1'b0);
    repeat (8) @(negedge clk);
    check("frame_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("frame_log_pat",   32'(log_pat[v0]), 32'h53);
    check("frame_pattern",   32'(bus.pattern), 32'h53);
    check("frame_latency",   32'(lat_valid), 32'd121);
    check("frame_busy_pre",  32'(busy_prev_at_valid), 32'h1);
    check("frame_busy_at",   32'(busy_at_valid), 32'h0);
    check("frame_no_err",    32'(err_cnt - e0), 32'd0);
    repeat (20) @(negedge clk);

    // Glitch start: four cycles high is long enough to debounce but not to survive to the midpoint.
    v0 = valid_cnt;
    e0 = err_cnt;
    bus.pin_in = 1'b1;
    repeat (4) @(negedge clk);
    bus.pin_in = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("glitch_latency", 32'(lat_err), 32'd9);
    check("glitch_busy",    32'(bus.busy), 32'h0);
    check("glitch_pattern", 32'(bus.pattern), 32'h53);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Single-cycle bounces inside a high slot and inside a low slot.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'b0101_0011, 1'b1);
    repeat (8) @(negedge clk);
    check("bounce_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("bounce_pattern",   32'(log_pat[v0]), 32'h53);
    check("bounce_no_err",    32'(err_cnt - e0), 32'd0);
    repeat (20) @(negedge clk);

    // Continuous stream of 0x07, frames back to back.
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int r = 0; r < 5; r++) send_frame(8'h07, 1'b0);
    repeat (8) @(negedge clk);
    check("stream_valid_cnt", 32'(valid_cnt - v0), 32'd5);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("stream_pat%0d", i), 32'(log_pat[v0 + i]), 32'h07);
      check($sformatf("stream_period%0d", i), 32'(log_t[v0 + i] - log_t[v0 + i - 1]), 32'd128);
    end
    check("stream_no_err", 32'(err_cnt - e0), 32'd0);
    check("stream_pattern", 32'(bus.pattern), 32'h07);
    repeat (20) @(negedge clk);

    // Reset during slot 4 of the clean frame.
    for (int k = 0; k < 4; k++) begin
      bus.pin_in = k < 2;
      repeat (SLOT) @(negedge clk);
    end
    bus.pin_in = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pattern", 32'(bus.pattern), 32'h0);
    check("mid_rst_busy",    32'(bus.busy),    32'h0);
    check("mid_rst_valid",   32'(bus.valid),   32'h0);
    check("mid_rst_err",     32'(bus.err),     32'h0);
    @(negedge clk);
    bus.pin_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'h0);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'b0101_0011, 1'b0);
    repeat (8) @(negedge clk);
    check("post_rst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("post_rst_pattern",   32'(bus.pattern), 32'h53);
    check("post_rst_no_err",    32'(err_cnt - e0), 32'd0);

    check("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
